// File: rtl/timestamp_pkg.sv
// Shared widths and the timestamp type used by the capture block and its consumers.
package timestamp_pkg;

   localparam int TS_W     = 32;
   localparam int TS_DEPTH = 4;

   typedef logic [TS_W-1:0] ts_t;

endpackage

// File: rtl/edge_sync_detect.sv
// Brings an asynchronous event line into the clk domain and flags each rising edge
// with a single-cycle pulse.
module edge_sync_detect (
   input  logic clk,
   input  logic reset,
   input  logic event_in,
   output logic edge_o
);

   logic sync0_q;
   logic sync1_q;
   logic prev_q;

   // Two flops for metastability, then one more to remember the previous settled level.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync0_q <= 1'b0;
         sync1_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync0_q <= event_in;
         sync1_q <= sync0_q;
         prev_q  <= sync1_q;
      end
   end

   assign edge_o = sync1_q & ~prev_q;

endmodule

// File: rtl/timestamp_capture.sv
// Latches the upstream counter on every synchronized event edge into a small
// first-word-fall-through FIFO, drained over a valid/ready handshake.
module timestamp_capture
   import timestamp_pkg::*;
#(
   parameter int N     = TS_W,
   parameter int DEPTH = TS_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N-1:0]             q,
   input  logic                     event_in,
   input  logic                     cap_en,
   output logic [N-1:0]             ts_data,
   output logic                     ts_valid,
   input  logic                     ts_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   localparam int PW = $clog2(DEPTH) + 1;
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] ONE = PW'(1);

   logic [N-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [PW-1:0] level_q, level_d;
   logic          overflow_q, overflow_d;

   logic edgePulse;
   logic push;
   logic pop;
   logic full;
   logic empty;
   logic wrEn;
   logic drop;

   edge_sync_detect u_edge (
      .clk      (clk),
      .reset    (reset),
      .event_in (event_in),
      .edge_o   (edgePulse)
   );

   // A push into a full FIFO still succeeds when the head leaves in the same cycle.
   always_comb begin
      empty      = (wrPtr_q == rdPtr_q);
      full       = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[PW-1] != rdPtr_q[PW-1]);
      push       = edgePulse & cap_en;
      pop        = ~empty & ts_ready;
      wrEn       = push & (~full | pop);
      drop       = push & full & ~pop;

      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      level_d    = level_q;
      overflow_d = overflow_q;

      if (wrEn) wrPtr_d = wrPtr_q + ONE;
      if (pop)  rdPtr_d = rdPtr_q + ONE;

      if (wrEn && !pop)      level_d = level_q + ONE;
      else if (!wrEn && pop) level_d = level_q - ONE;

      if (drop)         overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not cleared on reset; the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (reset && wrEn) begin
         mem_q[wrPtr_q[AW-1:0]] <= q;
      end
   end

   assign ts_data  = mem_q[rdPtr_q[AW-1:0]];
   assign ts_valid = ~empty;
   assign level    = level_q;
   assign overflow = overflow_q;

endmodule

// File: doc/timestamp_capture.md
Name: timestamp_capture

Overview:
- Downstream consumer of the free-running N-bit counter value `q`.
- On each rising edge of an asynchronous event input, latches the counter value into a small FIFO.
- Presents captured timestamps to a consumer over a valid/ready handshake.
- Flags a sticky overflow when a timestamp is lost.

Parameters:
- N, 32, width of the counter value and of each timestamp.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- q  input  N  counter value from the upstream counter.
- event_in  input  1  asynchronous event line.
- cap_en  input  1  capture enable; when 0, detected edges are discarded.
- ts_data  output  N  timestamp at the FIFO head; valid only while ts_valid=1.
- ts_valid  output  1  FIFO non-empty.
- ts_ready  input  1  consumer accepts the head entry when ts_valid and ts_ready are both 1 at a clock edge.
- level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
- overflow  output  1  sticky lost-event flag.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (reset=0 at a clock edge): sync0, sync1, prev, pointers, level, overflow all become 0. ts_valid=0. ts_data is don't-care but driven from storage (no X-gating required). Reset has priority over every other input, including mid-operation; FIFO contents are discarded.
- Synchronizer: sync0<=event_in, sync1<=sync0, prev<=sync1.
  - edge = sync1 & ~prev (combinational).
  - push = edge & cap_en.
- Latency: event_in goes high before edge k. The push occurs at edge k+2 and captures the value of q present at edge k+2. ts_valid rises after edge k+2 if the FIFO was empty.
- Edge semantics:
  - A level held high produces exactly one push.
  - event_in pulses shorter than one clock period may be missed; this is permitted.
  - event_in high across reset release produces one push, 2 cycles after release.
- pop = ts_valid & ts_ready.
- FIFO organisation:
  - First-word-fall-through: ts_data = mem[rd_ptr].
  - Pointers are $clog2(DEPTH)+1 bits with an extra wrap bit. Full when the pointers differ only in the MSB; empty when equal. Indices wrap modulo DEPTH.
- FIFO update cases:
  - push only, not full: write, wr_ptr+1, level+1.
  - push only, full: data dropped; overflow<=1; pointers and level unchanged.
  - pop only: rd_ptr+1, level-1.
  - push and pop in the same cycle, not empty: both occur, level unchanged. This holds when full: the push is accepted and overflow is not set.
  - push and pop while empty: pop is impossible (ts_valid=0); push only.
- Overflow flag:
  - ovf_clr=1 clears overflow.
  - If a drop and ovf_clr coincide, the set wins and overflow=1.
- No arithmetic is performed on timestamps. Counter wrap-around in q is captured as-is; the consumer handles modulo-2^N differences.
- All outputs are registered except ts_data (mem read mux) and ts_valid (level != 0, derived from registered pointers).

Decomposition:
- Package timestamp_pkg:
  - localparam TS_W = 32.
  - localparam TS_DEPTH = 4.
  - typedef logic [TS_W-1:0] ts_t.
- One sub-module: edge_sync_detect. It contains the 2-flop synchronizer plus prev register, outputs a 1-cycle `edge` pulse, and uses the same clk and active-low synchronous reset.
- FIFO storage and pointers live in the top module.

Test Plan:
All scenarios use an upstream counter incrementing every cycle.
- Reset: hold reset=0 for 3 cycles with event_in toggling -> ts_valid=0, level=0, overflow=0 throughout and on the first cycle after release.
- Single capture: raise event_in before the edge where q=100, ts_ready=0 -> after the edge where q=102, ts_valid=1, ts_data=102, level=1. Hold event_in high 10 cycles -> level stays 1. Pulse ts_ready for 1 cycle -> level=0, ts_valid=0.
- Overflow: ts_ready=0, 5 events spaced 4 cycles apart with the first at q=200 -> level=4 and overflow=1 after the 5th push. Drain -> ts_data sequence 202, 206, 210, 214. Pulse ovf_clr -> overflow=0.
- Full with simultaneous pop: with level=4, hold ts_ready=1 during the push edge -> level stays 4, overflow stays 0. The newest timestamp is appended at the tail and the oldest is popped.
- cap_en gating: cap_en=0, event rises at q=300 -> no push, level=0. Set cap_en=1 with event_in still high -> still no push (edge already consumed); the next rising edge captures.
- Reset mid-operation: level=3, overflow=1, assert reset=0 for 1 cycle -> level=0, ts_valid=0, overflow=0. A subsequent event captures normally into entry 0.
